// File: rtl/pipo_ctrl_pkg.sv
// Shared definitions for the PIPO load arbiter.
//   state_t : FSM state encoding (IDLE, LOAD, HOLD)
//   CNT_W   : width of the hold-window counter (HOLD_CYC ranges 0..15)
//   clog2   : index width helper, never returns less than 1
package pipo_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int CNT_W = 4;

    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/pipo_rr_pick.sv
// Combinational round-robin pick: rotate the request vector down by the
// pointer, take the lowest set bit, then rotate the index back up.
// Ports:
//   req : per-requester request bits
//   ptr : current highest-priority requester index
//   any : at least one request is set
//   win : index of the winning requester (valid when any=1)
module pipo_rr_pick
    import pipo_ctrl_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]          req,
    input  logic [clog2(N)-1:0]   ptr,
    output logic                  any,
    output logic [clog2(N)-1:0]   win
);

    localparam int IW = clog2(N);

    logic [2*N-1:0] dbl;
    logic [IW:0]    shift;
    logic [N-1:0]   rot;
    int             offset;
    int             sum;

    // NOTE: combinational logic uses blocking assignments, and every signal is
    // assigned at the top of the block so no path leaves it unassigned (no latch).
    always_comb begin
        dbl    = {req, req};
        shift  = {1'b0, ptr};
        rot    = dbl[shift +: N];
        offset = 0;
        // Scan downward so the lowest set bit is the last one written.
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j]) offset = j;
        end
        sum = int'(ptr) + offset;
        if (sum >= N) sum = sum - N;
        any = |req;
        win = IW'(sum);
    end

endmodule

// File: rtl/pipo_load_arbiter.sv
// Round-robin arbiter and load sequencer in front of a shared W-bit PIPO
// register. One winner per round gets a single-cycle load of its data word,
// after which the register is held stable for HOLD_CYC cycles.
// Ports:
//   clk     : rising-edge clock
//   rst     : synchronous active-high reset
//   req     : per-requester level request
//   din     : flattened data, requester i at din[i*W +: W]
//   gnt     : one-hot grant, high only in the LOAD cycle
//   load    : PIPO load strobe, coincident with gnt
//   x       : PIPO data input; winner's data, held afterwards
//   owner   : index of the most recently granted requester
//   q_valid : high during HOLD, PIPO q holds owner's data
//   busy    : high in LOAD or HOLD
module pipo_load_arbiter
    import pipo_ctrl_pkg::*;
#(
    parameter int N        = 4,
    parameter int W        = 4,
    parameter int HOLD_CYC = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          req,
    input  logic [N*W-1:0]        din,
    output logic [N-1:0]          gnt,
    output logic                  load,
    output logic [W-1:0]          x,
    output logic [clog2(N)-1:0]   owner,
    output logic                  q_valid,
    output logic                  busy
);

    localparam int IW = clog2(N);

    state_t           state;
    logic [IW-1:0]    ptr;
    logic [CNT_W-1:0] cnt;
    logic             any;
    logic [IW-1:0]    win;

    pipo_rr_pick #(.N(N)) u_pick (
        .req (req),
        .ptr (ptr),
        .any (any),
        .win (win)
    );

    // NOTE: all state and outputs are registered with non-blocking assignments
    // so every register updates from values sampled at the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            cnt     <= '0;
            gnt     <= '0;
            load    <= 1'b0;
            x       <= '0;
            owner   <= '0;
            q_valid <= 1'b0;
            busy    <= 1'b0;
        end else begin
            // gnt and load are single-cycle pulses by default.
            gnt  <= '0;
            load <= 1'b0;
            case (state)
                IDLE: begin
                    q_valid <= 1'b0;
                    busy    <= 1'b0;
                    if (any) begin
                        state <= LOAD;
                        gnt   <= {{(N-1){1'b0}}, 1'b1} << win;
                        load  <= 1'b1;
                        x     <= din[win*W +: W];
                        owner <= win;
                        busy  <= 1'b1;
                        ptr   <= (win == IW'(N - 1)) ? '0 : win + 1'b1;
                    end
                end
                LOAD: begin
                    if (HOLD_CYC > 0) begin
                        state   <= HOLD;
                        cnt     <= CNT_W'(HOLD_CYC);
                        q_valid <= 1'b1;
                        busy    <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                HOLD: begin
                    // cnt counts remaining HOLD cycles including this one.
                    if (cnt <= CNT_W'(1)) begin
                        state   <= IDLE;
                        q_valid <= 1'b0;
                        busy    <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    q_valid <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipo_load_arbiter.sv
module tb_pipo_load_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] din;
    logic [3:0]  gnt;
    logic        load;
    logic [3:0]  x;
    logic [1:0]  owner;
    logic        q_valid;
    logic        busy;

    // Second build with HOLD_CYC=0.
    logic [3:0]  req0;
    logic [15:0] din0;
    logic [3:0]  gnt0;
    logic        load0;
    logic [3:0]  x0;
    logic [1:0]  owner0;
    logic        q_valid0;
    logic        busy0;

    // Behavioural PIPO on the main instance's load/x.
    logic [3:0]  pipo_q;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;

    always #5 clk = ~clk;

    always @(posedge clk) if (load) pipo_q <= x;

    pipo_load_arbiter #(.N(4), .W(4), .HOLD_CYC(2)) dut (
        .clk(clk), .rst(rst), .req(req), .din(din),
        .gnt(gnt), .load(load), .x(x), .owner(owner),
        .q_valid(q_valid), .busy(busy)
    );

    pipo_load_arbiter #(.N(4), .W(4), .HOLD_CYC(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .din(din0),
        .gnt(gnt0), .load(load0), .x(x0), .owner(owner0),
        .q_valid(q_valid0), .busy(busy0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next load pulse on the main instance, bounded.
    task automatic wait_load(input string tag, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!load && cycles < 12);
        check({tag, "_load"}, {31'd0, load}, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    logic [3:0] exp_w [5];
    logic [3:0] exp_x [5];

    initial begin
        rst  = 1'b1;
        req  = '0;
        din  = '0;
        req0 = '0;
        din0 = '0;

        // Reset then idle.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_outs", {16'd0, gnt, load, x, owner, q_valid, busy}, 32'd0);
        end

        // Single requester 2 with data B.
        req = 4'b0100;
        din = 16'h0B00;
        @(negedge clk);
        check("single_gnt",   {28'd0, gnt}, 32'h4);
        check("single_load",  {31'd0, load}, 32'd1);
        check("single_x",     {28'd0, x}, 32'hB);
        check("single_owner", {30'd0, owner}, 32'd2);
        check("single_qv_load", {31'd0, q_valid}, 32'd0);
        req = '0;
        @(negedge clk);
        check("single_qv1",  {31'd0, q_valid}, 32'd1);
        check("single_ld1",  {31'd0, load}, 32'd0);
        check("single_pipo", {28'd0, pipo_q}, 32'hB);
        @(negedge clk);
        check("single_qv2",  {31'd0, q_valid}, 32'd1);
        @(negedge clk);
        check("single_qv3",  {30'd0, q_valid, busy}, 32'd0);
        check("single_xhold", {28'd0, x}, 32'hB);

        // Round-robin fairness from a fresh pointer.
        do_reset();
        exp_w = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_x = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hA};
        req = 4'b1111;
        din = 16'hDCBA;
        for (int k = 0; k < 5; k++) begin
            wait_load("rr", cyc);
            check("rr_spacing", cyc, (k == 0) ? 32'd1 : 32'd4);
            check("rr_gnt", {28'd0, gnt}, {28'd0, exp_w[k]});
            check("rr_x",   {28'd0, x}, {28'd0, exp_x[k]});
        end
        req = '0;
        repeat (4) @(negedge clk);

        // Wrap: grant 3 first, then 1001 must go 0 then 3.
        do_reset();
        req = 4'b1000;
        din = 16'h7005;
        wait_load("wrap3", cyc);
        check("wrap3_gnt",   {28'd0, gnt}, 32'h8);
        check("wrap3_owner", {30'd0, owner}, 32'd3);
        req = 4'b1001;
        wait_load("wrap0", cyc);
        check("wrap0_gnt", {28'd0, gnt}, 32'h1);
        check("wrap0_x",   {28'd0, x}, 32'h5);
        wait_load("wrap3b", cyc);
        check("wrap3b_gnt", {28'd0, gnt}, 32'h8);
        check("wrap3b_x",   {28'd0, x}, 32'h7);
        req = '0;
        repeat (4) @(negedge clk);

        // Reset during the first HOLD cycle; pointer must return to 0.
        req = 4'b0010;
        din = 16'h4321;
        wait_load("mid", cyc);
        check("mid_gnt", {28'd0, gnt}, 32'h2);
        req = '0;
        @(negedge clk);
        check("mid_hold_qv", {31'd0, q_valid}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_outs", {26'd0, gnt, load, q_valid, busy}, 32'd0);
        rst = 1'b0;
        req = 4'b1111;
        @(negedge clk);
        check("mid_ptr_gnt", {28'd0, gnt}, 32'h1);
        req = '0;
        repeat (4) @(negedge clk);

        // HOLD_CYC=0 build: alternate 0 and 1 every 2 cycles.
        req0 = 4'b0011;
        din0 = 16'h0021;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i % 2 == 0) begin
                check("h0_gnt",  {28'd0, gnt0}, ((i / 2) % 2 == 0) ? 32'h1 : 32'h2);
                check("h0_x",    {28'd0, x0},   ((i / 2) % 2 == 0) ? 32'h1 : 32'h2);
                check("h0_load", {31'd0, load0}, 32'd1);
            end else begin
                check("h0_idle", {27'd0, gnt0, load0}, 32'd0);
            end
            check("h0_qv", {31'd0, q_valid0}, 32'd0);
        end
        req0 = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
